// File: rtl/hack_cpu_seq.sv
// Multi-cycle Hack CPU control/register stage: FETCH -> EXEC -> (MEMRD) -> COMPUTE.
// Optional macro HACK_CPU_HALT_EN adds a terminal HALT state on a taken jump-to-self.
module hack_cpu_seq #(
  parameter int                  PC_WIDTH = 15,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [15:0]         instr,
  input  logic                instr_valid,
  input  logic [15:0]         inM,
  input  logic                inM_valid,
  output logic                fetch_req,
  output logic                read_req,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] addressM,
  output logic [15:0]         outM,
  output logic                writeM,
  output logic                halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_MEMRD,
    S_COMPUTE
`ifdef HACK_CPU_HALT_EN
    , S_HALT
`endif
  } state_t;

  state_t              r_state;
  logic [15:0]         r_ir;
  logic [15:0]         r_a;
  logic [15:0]         r_d;
  logic [15:0]         r_m;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_waddr;
  logic [15:0]         r_outM;
  logic                r_writeM;
  logic                r_fetch_req;
  logic                r_read_req;
`ifdef HACK_CPU_HALT_EN
  logic                r_halted;
`endif

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xs;
    logic [15:0] ys;
    logic [15:0] o;
    xs = c[5] ? 16'h0000 : x;
    xs = c[4] ? ~xs : xs;
    ys = c[3] ? 16'h0000 : y;
    ys = c[2] ? ~ys : ys;
    o  = c[1] ? (xs + ys) : (xs & ys);
    return c[0] ? ~o : o;
  endfunction

  logic signed [15:0]  w_alu;
  logic [15:0]         w_y;
  logic                w_zr;
  logic                w_ng;
  logic                w_jmp;
  logic [PC_WIDTH-1:0] w_tgt;
  logic [PC_WIDTH-1:0] w_pc_inc;

  assign w_y      = r_ir[12] ? r_m : r_a;
  assign w_alu    = hack_alu(r_d, w_y, r_ir[11:6]);
  assign w_zr     = (w_alu == 16'sd0);
  assign w_ng     = (w_alu < 16'sd0);
  assign w_jmp    = (r_ir[2] & w_ng) | (r_ir[1] & w_zr) | (r_ir[0] & ~w_ng & ~w_zr);
  assign w_tgt    = r_a[PC_WIDTH-1:0];
  assign w_pc_inc = r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};

`ifdef HACK_CPU_HALT_EN
  logic w_halt;
  assign w_halt = w_jmp && (w_tgt == r_pc);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_ir        <= '0;
      r_a         <= '0;
      r_d         <= '0;
      r_m         <= '0;
      r_pc        <= RESET_PC;
      r_waddr     <= '0;
      r_outM      <= '0;
      r_writeM    <= 1'b0;
      r_fetch_req <= 1'b1;
      r_read_req  <= 1'b0;
`ifdef HACK_CPU_HALT_EN
      r_halted    <= 1'b0;
`endif
    end else begin
      r_writeM <= 1'b0;
      unique case (r_state)
        S_FETCH: begin
          if (instr_valid) begin
            r_ir        <= instr;
            r_fetch_req <= 1'b0;
            r_state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!r_ir[15]) begin
            r_a         <= r_ir;
            r_pc        <= w_pc_inc;
            r_fetch_req <= 1'b1;
            r_state     <= S_FETCH;
          end else if (r_ir[12]) begin
            r_read_req  <= 1'b1;
            r_state     <= S_MEMRD;
          end else begin
            r_state     <= S_COMPUTE;
          end
        end
        S_MEMRD: begin
          if (inM_valid) begin
            r_m        <= inM;
            r_read_req <= 1'b0;
            r_state    <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          // Write address and jump target both come from the pre-update A.
          if (r_ir[5]) r_a <= w_alu;
          if (r_ir[4]) r_d <= w_alu;
          r_outM  <= w_alu;
          r_waddr <= w_tgt;
          r_pc    <= w_jmp ? w_tgt : w_pc_inc;
`ifdef HACK_CPU_HALT_EN
          if (w_halt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_writeM    <= r_ir[3];
            r_fetch_req <= 1'b1;
            r_state     <= S_FETCH;
          end
`else
          r_writeM    <= r_ir[3];
          r_fetch_req <= 1'b1;
          r_state     <= S_FETCH;
`endif
        end
`ifdef HACK_CPU_HALT_EN
        S_HALT: r_state <= S_HALT;
`endif
        default: begin
          r_fetch_req <= 1'b1;
          r_read_req  <= 1'b0;
          r_state     <= S_FETCH;
        end
      endcase
    end
  end

  assign fetch_req = r_fetch_req;
  assign read_req  = r_read_req;
  assign pc        = r_pc;
  // During the write strobe the address must stay on the pre-update A.
  assign addressM  = r_writeM ? r_waddr : r_a[PC_WIDTH-1:0];
  assign outM      = r_outM;
  assign writeM    = r_writeM;
`ifdef HACK_CPU_HALT_EN
  assign halted    = r_halted;
`else
  assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_hack_cpu_seq.sv
// Scoreboard bench for hack_cpu_seq: an instruction-level Hack model predicts fetch
// addresses, read addresses and memory writes; a monitor compares DUT handshakes.
module tb_hack_cpu_seq;
`ifdef HACK_CPU_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] inM;
  logic        inM_valid;
  logic        fetch_req;
  logic        read_req;
  logic [14:0] pc;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic        halted;

  always #5 clock = ~clock;

  hack_cpu_seq #(.PC_WIDTH(15), .RESET_PC(15'd0)) dut (
    .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .inM(inM), .inM_valid(inM_valid), .fetch_req(fetch_req), .read_req(read_req),
    .pc(pc), .addressM(addressM), .outM(outM), .writeM(writeM), .halted(halted)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit abort  = 1'b0;

  // Architectural model state
  logic [15:0] mA, mD;
  logic [14:0] mpc;
  bit          m_halted;
  logic [14:0] q_fetch[$];
  logic [14:0] q_rd[$];
  logic [30:0] q_wr[$];

  logic [5:0] comps[18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000,
                            6'b001101, 6'b110001, 6'b001111, 6'b110011, 6'b011111,
                            6'b110111, 6'b001110, 6'b110010, 6'b000010, 6'b010011,
                            6'b000111, 6'b000000, 6'b010101};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Hack comp mnemonics evaluated directly as arithmetic on D and A/M.
  function automatic logic [15:0] ref_comp(input logic [5:0] c, input logic [15:0] d,
                                           input logic [15:0] y);
    case (c)
      6'b101010: return 16'd0;
      6'b111111: return 16'd1;
      6'b111010: return 16'hFFFF;
      6'b001100: return d;
      6'b110000: return y;
      6'b001101: return ~d;
      6'b110001: return ~y;
      6'b001111: return 16'd0 - d;
      6'b110011: return 16'd0 - y;
      6'b011111: return d + 16'd1;
      6'b110111: return y + 16'd1;
      6'b001110: return d - 16'd1;
      6'b110010: return y - 16'd1;
      6'b000010: return d + y;
      6'b010011: return d - y;
      6'b000111: return y - d;
      6'b000000: return d & y;
      6'b010101: return d | y;
      default:   return 16'hDEAD;
    endcase
  endfunction

  task automatic model_reset();
    mA = '0; mD = '0; mpc = '0; m_halted = 1'b0;
    q_fetch.delete(); q_rd.delete(); q_wr.delete();
  endtask

  task automatic model_step(input logic [15:0] ins, input logic [15:0] mval, output bit hlt);
    logic [15:0] y, r;
    logic signed [15:0] s;
    bit taken;
    hlt = 1'b0;
    if (!ins[15]) begin
      mA  = ins;
      mpc = mpc + 15'd1;
    end else begin
      if (ins[12]) q_rd.push_back(mA[14:0]);
      y = ins[12] ? mval : mA;
      r = ref_comp(ins[11:6], mD, y);
      s = r;
      taken = (ins[2] && s < 0) || (ins[1] && s == 0) || (ins[0] && s > 0);
      hlt = HALT_EN && taken && (mA[14:0] == mpc);
      if (ins[3] && !hlt) q_wr.push_back({mA[14:0], r});
      mpc = taken ? mA[14:0] : mpc + 15'd1;
      if (ins[5]) mA = r;
      if (ins[4]) mD = r;
    end
    if (hlt) m_halted = 1'b1;
  endtask

  task automatic monitor();
    logic [30:0] w;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (fetch_req && instr_valid) begin
          if (q_fetch.size() == 0) check("unexpected_fetch", 32'd1, 32'd0);
          else check("fetch_pc", pc, q_fetch.pop_front());
        end
        if (read_req && inM_valid) begin
          if (q_rd.size() == 0) check("unexpected_read", 32'd1, 32'd0);
          else check("read_addr", addressM, q_rd.pop_front());
        end
        if (writeM) begin
          if (q_wr.size() == 0) check("unexpected_write", {17'd0, addressM}, 32'hFFFFFFFF);
          else begin
            w = q_wr.pop_front();
            check("wr_addr", addressM, w[30:16]);
            check("wr_data", outM, w[15:0]);
          end
        end
      end
    end
  endtask

  task automatic issue(input logic [15:0] ins, input logic [15:0] mval, input int idly,
                       input int mdly);
    int n, lat, mw, exp_lat;
    bit hlt;
    if (abort) return;
    n = 0;
    while (!fetch_req && n < 50) begin @(posedge clock); #1; n++; end
    if (!fetch_req) begin
      check("fetch_timeout", fetch_req, 1);
      abort = 1'b1;
      return;
    end
    repeat (idly) begin @(posedge clock); #1; end
    q_fetch.push_back(mpc);
    model_step(ins, mval, hlt);
    instr = ins; instr_valid = 1'b1;
    @(posedge clock); #1;
    instr_valid = 1'b0; instr = 16'($urandom);
    if (hlt) begin
      repeat (6) @(posedge clock);
      #1;
      check("halt_fetch_req", fetch_req, 0);
      check("halt_halted", halted, 1);
      check("halt_writeM", writeM, 0);
      check("halt_pc", pc, mpc);
      return;
    end
    exp_lat = !ins[15] ? 1 : (ins[12] ? mdly + 3 : 2);
    lat = 0; mw = 0;
    while (!fetch_req && lat < 50) begin
      if (read_req) begin
        if (mw == mdly) begin inM = mval; inM_valid = 1'b1; end
        mw++;
      end
      @(posedge clock); #1;
      inM_valid = 1'b0; lat++;
    end
    check("latency", lat, exp_lat);
    if (!fetch_req) abort = 1'b1;
    check("halted_low", halted, 0);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    mon_en = 1'b0; reset = 1'b1; instr_valid = 1'b0; inM_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    mon_en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ins;
    int n;
    instr = '0; instr_valid = 1'b0; inM = '0; inM_valid = 1'b0; reset = 1'b1;
    fork monitor(); join_none
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_pc", pc, 0);
    check("rst_fetch_req", fetch_req, 1);
    check("rst_read_req", read_req, 0);
    check("rst_writeM", writeM, 0);
    check("rst_halted", halted, 0);
    check("rst_addressM", addressM, 0);
    model_reset();
    mon_en = 1'b1;

    // @5; D=A; M=D
    issue(16'h0005, 16'h0, 0, 0);
    issue(16'hEC10, 16'h0, 1, 0);
    issue(16'hE308, 16'h0, 0, 0);
    // A=3, D=4, M=D+A;JMP
    issue(16'h0004, 16'h0, 0, 0);
    issue(16'hEC10, 16'h0, 0, 0);
    issue(16'h0003, 16'h0, 2, 0);
    issue(16'hE08F, 16'h0, 0, 0);
    // AM=D;JMP with pre-update A, then M=A
    issue(16'h0014, 16'h0, 0, 0);
    issue(16'hEC10, 16'h0, 0, 0);
    issue(16'h0009, 16'h0, 0, 0);
    issue(16'hE32F, 16'h0, 0, 0);
    issue(16'hEC08, 16'h0, 0, 0);
    // @10; D=M (slow read of 0x8000); D;JLT; D;JGT
    issue(16'h000A, 16'h0, 0, 0);
    issue(16'hFC10, 16'h8000, 0, 5);
    issue(16'hE304, 16'h0, 0, 0);
    issue(16'hE301, 16'h0, 0, 0);
    issue(16'h0001, 16'h0, 0, 0);

    // Reset in MEMRD while inM_valid is high
    @(posedge clock); #1;
    mon_en = 1'b0;
    n = 0;
    while (!fetch_req && n < 50) begin @(posedge clock); #1; n++; end
    instr = 16'hFC10; instr_valid = 1'b1;
    @(posedge clock); #1;
    instr_valid = 1'b0;
    @(posedge clock); #1;
    check("memrd_entered", read_req, 1);
    reset = 1'b1; inM = 16'h1234; inM_valid = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; inM_valid = 1'b0;
    check("rst2_pc", pc, 0);
    check("rst2_fetch_req", fetch_req, 1);
    check("rst2_read_req", read_req, 0);
    check("rst2_writeM", writeM, 0);
    check("rst2_addressM", addressM, 0);
    model_reset();
    mon_en = 1'b1;
    issue(16'hE308, 16'h0, 0, 0);

    // pc wrap: jump to 0x7FFF, then a non-jump instruction
    issue(16'h7FFF, 16'h0, 0, 0);
    issue(16'hEA87, 16'h0, 0, 0);
    issue(16'hEC10, 16'h0, 0, 0);
    issue(16'h0000, 16'h0, 0, 0);

    // Randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 4) ins = {1'b0, 15'($urandom)};
      else begin
        ins = {1'b1, 2'($urandom), 1'($urandom), comps[$urandom_range(0, 17)],
               3'($urandom), 3'($urandom)};
        if (mA[14:0] == mpc) ins[2:0] = 3'b000;
      end
      issue(ins, 16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Jump-to-self program
    do_reset();
    issue(16'h0006, 16'h0, 0, 0);
    issue(16'hEA87, 16'h0, 0, 0);
    issue(16'h0006, 16'h0, 0, 0);
    issue(16'hEA87, 16'h0, 0, 0);
    issue(16'h0007, 16'h0, 0, 0);
    issue(16'hEA87, 16'h0, 0, 0);
    if (!m_halted) issue(16'h0007, 16'h0, 0, 0);
    check("halted_final", halted, m_halted);

    repeat (3) @(posedge clock);
    #1;
    check("q_fetch_empty", q_fetch.size(), 0);
    check("q_rd_empty", q_rd.size(), 0);
    check("q_wr_empty", q_wr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
